wb_stage_writer: RTL
====================

// Module: wb_stage_writer
// PURPOSE
//  Writeback pipeline stage: the initiator that drives the register file write port.
//  Accepts one instruction per cycle from the memory stage via valid/allowin handshake,
//  holds it in a single stage register and emits the rf write (wen/waddr/wbytes/wdata)
//  in the cycle it completes. Also exports destination info for decode-stage hazard
//  detection, the retired PC for trace, and a retired-instruction counter.
// PARAMETERS
//  DATA_W  32  register data width
//  ADDR_W  5   register index width
//  PC_W    32  PC width
//  CNT_W   32  retire counter width
// PORTS
//  clk             in   1       clock, all state on rising edge
//  reset           in   1       asynchronous, active-high reset
//  ms_to_ws_valid  in   1       memory stage presents an instruction
//  ms_pc           in   PC_W    its PC
//  ms_gr_we        in   1       instruction writes a GPR
//  ms_dest         in   ADDR_W  destination register index
//  ms_wbytes       in   4       byte-lane write enables (4'hf = full word)
//  ms_result       in   DATA_W  write data, lanes already aligned
//  ws_stall        in   1       hold current instruction (not ready to go)
//  ws_flush        in   1       discard stage contents (exception/ertn)
//  ws_allowin      out  1       stage can accept ms_* this cycle
//  rf_wen          out  1       register file write enable
//  rf_waddr        out  ADDR_W  register file write index
//  rf_wbytes       out  4       register file byte enables
//  rf_wdata        out  DATA_W  register file write data
//  ws_dest_valid   out  1       stage holds a live GPR writer (for hazard logic)
//  ws_dest         out  ADDR_W  its destination index
//  debug_wb_pc     out  PC_W    PC of instruction completing this cycle
//  retire_cnt      out  CNT_W   instructions retired since reset
// BEHAVIOUR
//  - Reset (async, immediate): ws_valid=0, payload regs=0, retire_cnt=0 -> all rf_*,
//    ws_dest_valid, ws_dest, debug_wb_pc read 0; ws_allowin=1.
//  - ws_ready_go = !ws_stall; ws_allowin = !ws_valid || ws_ready_go (combinational).
//  - Edge update, priority: ws_flush -> ws_valid<=0 (ms_* ignored that cycle);
//    else if ws_allowin -> ws_valid<=ms_to_ws_valid, payload captured only when
//    ms_to_ws_valid=1; else hold everything.
//  - Completion cycle C = ws_valid && ws_ready_go && !ws_flush. Latency: accepted at
//    edge N -> rf write visible on rf_* during cycle N+1 (if not stalled); regfile
//    commits at edge N+2 start, i.e. the edge ending that cycle.
//  - rf_wbytes = (C && gr_we) ? wbytes : 4'h0; rf_wen = |rf_wbytes && dest!=0.
//    rf_waddr/rf_wdata = payload when rf_wen, else 0. Dest 0 never asserts rf_wen.
//  - Stalled cycles: rf_wen=0; write occurs exactly once, in the releasing cycle.
//  - ws_dest_valid = ws_valid && gr_we && dest!=0 && |wbytes (asserted while stalled);
//    ws_dest = dest when ws_dest_valid else 0.
//  - debug_wb_pc = C ? pc : 0.
//  - retire_cnt += 1 on every edge closing a C cycle (gr_we irrelevant); wraps to 0
//    after all-ones, no saturation.
//  - Back-to-back: completion and new acceptance in same cycle is allowed (full
//    throughput, one instr/cycle).
//  - Flush during stall: instruction dropped, no rf write, counter unchanged.
//  - Reset mid-stall/mid-write: pending write lost, no partial output.
// TESTING
//  1 Reset: assert reset mid-cycle -> rf_wen=0, ws_allowin=1, retire_cnt=0 immediately.
//  2 Stream 3 instrs (dest 1,2,3; data 'h11,'h22,'h33; wbytes f) valid every cycle ->
//    rf_wen high 3 consecutive cycles, one cycle after each accept; retire_cnt=3.
//  3 dest=0, ms_gr_we=1, data 'hdead -> rf_wen=0, ws_dest_valid=0, retire_cnt +1.
//  4 Accept dest=5 data 'h1234, ws_stall=1 for 3 cycles -> ws_allowin=0,
//    ws_dest_valid=1, ws_dest=5, rf_wen=0; release -> single write r5='h1234.
//  5 Stall then ws_flush=1 -> no rf write, ws_valid=0 next cycle, counter unchanged;
//    flush same cycle as ms_to_ws_valid -> new instr not captured.
//  6 Preload retire_cnt all-ones (force) and retire one -> retire_cnt=0.

Source files
------------

// File: rtl/wb_stage_writer.sv
// Writeback pipeline stage: single-entry stage register that drives the register file
// write port, exports live destination info for decode hazard checks, the retiring PC
// for trace, and a free-running retired-instruction counter.
module wb_stage_writer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ms_to_ws_valid,
    input  logic [PC_W-1:0]   ms_pc,
    input  logic              ms_gr_we,
    input  logic [ADDR_W-1:0] ms_dest,
    input  logic [3:0]        ms_wbytes,
    input  logic [DATA_W-1:0] ms_result,
    input  logic              ws_stall,
    input  logic              ws_flush,
    output logic              ws_allowin,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [3:0]        rf_wbytes,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              ws_dest_valid,
    output logic [ADDR_W-1:0] ws_dest,
    output logic [PC_W-1:0]   debug_wb_pc,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int unsigned WB_W = 4;

    logic              r_ws_valid;
    logic [PC_W-1:0]   r_pc;
    logic              r_gr_we;
    logic [ADDR_W-1:0] r_dest;
    logic [WB_W-1:0]   r_wbytes;
    logic [DATA_W-1:0] r_result;
    logic [CNT_W-1:0]  r_retire_cnt;

    logic              w_ready_go;
    logic              w_complete;
    logic [WB_W-1:0]   w_wbytes;
    logic              w_wen;
    logic              w_dest_nz;

    // Handshake and completion qualifiers; a flush suppresses completion outright.
    assign w_ready_go = !ws_stall;
    assign ws_allowin = !r_ws_valid || w_ready_go;
    assign w_complete = r_ws_valid && w_ready_go && !ws_flush;
    assign w_dest_nz  = (r_dest != '0);

    // Register file write port: only active in the completing cycle, never for r0.
    assign w_wbytes    = (w_complete && r_gr_we) ? r_wbytes : WB_W'(0);
    assign w_wen       = (|w_wbytes) && w_dest_nz;
    assign rf_wbytes   = w_wbytes;
    assign rf_wen      = w_wen;
    assign rf_waddr    = w_wen ? r_dest   : ADDR_W'(0);
    assign rf_wdata    = w_wen ? r_result : DATA_W'(0);

    // Hazard export stays asserted while the writer is stalled in the stage.
    assign ws_dest_valid = r_ws_valid && r_gr_we && w_dest_nz && (|r_wbytes);
    assign ws_dest       = ws_dest_valid ? r_dest : ADDR_W'(0);

    assign debug_wb_pc = w_complete ? r_pc : PC_W'(0);
    assign retire_cnt  = r_retire_cnt;

    // Stage register: flush beats acceptance; payload loads only with a valid instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ws_valid <= 1'b0;
            r_pc       <= '0;
            r_gr_we    <= 1'b0;
            r_dest     <= '0;
            r_wbytes   <= '0;
            r_result   <= '0;
        end else if (ws_flush) begin
            r_ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            r_ws_valid <= ms_to_ws_valid;
            if (ms_to_ws_valid) begin
                r_pc     <= ms_pc;
                r_gr_we  <= ms_gr_we;
                r_dest   <= ms_dest;
                r_wbytes <= ms_wbytes;
                r_result <= ms_result;
            end
        end
    end

    // Retire counter: one per completed instruction, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retire_cnt <= '0;
        end else if (w_complete) begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

endmodule
